// File: rtl/sobel_pkg.sv
// Shared constants and types for the streaming Sobel engine.
package sobel_pkg;

  localparam int SOBEL_K_EDGE = 1;
  localparam int SOBEL_K_MID  = 2;

  typedef enum logic {
    MODE_MAG = 1'b0,
    MODE_BIN = 1'b1
  } mode_e;

  function automatic int grad_w(input int dw);
    return dw + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-line pixel store addressed by column; each word packs {row y-2, row y-1}.
module sobel_line_buf #(
  parameter  int IMG_W = 100,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(IMG_W)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   addr,
  input  logic [2*DW-1:0] wdata,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Asynchronous read; the write lands on the edge, so a same-cycle read sees old data.
  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge engine: counters, window, gradient pipeline, per-frame config.
module sobel_stream
  import sobel_pkg::*;
#(
  parameter int IMG_W = 100,
  parameter int IMG_H = 100,
  parameter int DW    = 8
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  input  logic            pi_flag,
  input  logic [DW-1:0]   pi_data,
  input  logic            cfg_mode,
  input  logic [DW+2:0]   cfg_thresh,
  output logic            po_flag,
  output logic [DW-1:0]   po_data,
  output logic            po_eof
);

  localparam int GW = grad_w(DW);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [DW-1:0]  win_q [3][3];
  logic [DW-1:0]  win_d [3][3];
  mode_e          mode_sh_q, mode_sh_d;
  logic [GW-1:0]  thr_sh_q, thr_sh_d;

  logic           v1_q, v1_d, eof1_q, eof1_d;
  mode_e          mode1_q, mode1_d;
  logic [GW-1:0]  thr1_q, thr1_d;

  logic           v2_q, v2_d, eof2_q, eof2_d;
  mode_e          mode2_q, mode2_d;
  logic [GW-1:0]  thr2_q, thr2_d;
  logic [GW-2:0]  ax_q, ax_d, ay_q, ay_d;

  logic           po_flag_q, po_flag_d, po_eof_q, po_eof_d;
  logic [DW-1:0]  po_data_q, po_data_d;

  logic [2*DW-1:0] lb_rdata;

  sobel_line_buf #(
    .IMG_W (IMG_W),
    .DW    (DW)
  ) u_line_buf (
    .clk   (sys_clk),
    .we    (pi_flag),
    .addr  (col_q),
    .wdata ({lb_rdata[DW-1:0], pi_data}),
    .rdata (lb_rdata)
  );

  int                   gx_full, gy_full;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        sum;
  logic                 first_pix;

  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    win_d     = win_q;
    mode_sh_d = mode_sh_q;
    thr_sh_d  = thr_sh_q;
    first_pix = (col_q == '0) && (row_q == '0);

    if (pi_flag) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb_rdata[2*DW-1:DW];
      win_d[1][2] = lb_rdata[DW-1:0];
      win_d[2][2] = pi_data;
      if (first_pix) begin
        mode_sh_d = mode_e'(cfg_mode);
        thr_sh_d  = cfg_thresh;
      end
    end

    // Config rides with each result so a new frame's shadow update cannot touch old results.
    v1_d    = pi_flag && (col_q >= CW'(2)) && (row_q >= RW'(2));
    eof1_d  = pi_flag && (col_q == COL_LAST) && (row_q == ROW_LAST);
    mode1_d = mode_sh_q;
    thr1_d  = thr_sh_q;

    gx_full = SOBEL_K_EDGE * int'(win_q[0][2]) + SOBEL_K_MID * int'(win_q[1][2])
            + SOBEL_K_EDGE * int'(win_q[2][2])
            - SOBEL_K_EDGE * int'(win_q[0][0]) - SOBEL_K_MID * int'(win_q[1][0])
            - SOBEL_K_EDGE * int'(win_q[2][0]);
    gy_full = SOBEL_K_EDGE * int'(win_q[2][0]) + SOBEL_K_MID * int'(win_q[2][1])
            + SOBEL_K_EDGE * int'(win_q[2][2])
            - SOBEL_K_EDGE * int'(win_q[0][0]) - SOBEL_K_MID * int'(win_q[0][1])
            - SOBEL_K_EDGE * int'(win_q[0][2]);
    gx      = GW'(gx_full);
    gy      = GW'(gy_full);
    ax_d    = gx[GW-1] ? (GW-1)'(-gx) : gx[GW-2:0];
    ay_d    = gy[GW-1] ? (GW-1)'(-gy) : gy[GW-2:0];
    v2_d    = v1_q;
    eof2_d  = eof1_q;
    mode2_d = mode1_q;
    thr2_d  = thr1_q;

    sum       = GW'(ax_q) + GW'(ay_q);
    po_flag_d = v2_q;
    po_eof_d  = v2_q && eof2_q;
    if (mode2_q == MODE_BIN) po_data_d = (sum >= thr2_q) ? '1 : '0;
    else                     po_data_d = (sum[GW-1:DW] != '0) ? '1 : sum[DW-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '{default: '0};
      mode_sh_q <= MODE_MAG;
      thr_sh_q  <= '0;
      v1_q      <= 1'b0;
      eof1_q    <= 1'b0;
      mode1_q   <= MODE_MAG;
      thr1_q    <= '0;
      v2_q      <= 1'b0;
      eof2_q    <= 1'b0;
      mode2_q   <= MODE_MAG;
      thr2_q    <= '0;
      ax_q      <= '0;
      ay_q      <= '0;
      po_flag_q <= 1'b0;
      po_eof_q  <= 1'b0;
      po_data_q <= '0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      mode_sh_q <= mode_sh_d;
      thr_sh_q  <= thr_sh_d;
      v1_q      <= v1_d;
      eof1_q    <= eof1_d;
      mode1_q   <= mode1_d;
      thr1_q    <= thr1_d;
      v2_q      <= v2_d;
      eof2_q    <= eof2_d;
      mode2_q   <= mode2_d;
      thr2_q    <= thr2_d;
      ax_q      <= ax_d;
      ay_q      <= ay_d;
      po_flag_q <= po_flag_d;
      po_eof_q  <= po_eof_d;
      po_data_q <= po_data_d;
    end
  end

  assign po_flag = po_flag_q;
  assign po_data = po_data_q;
  assign po_eof  = po_eof_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x8 image: flat, step edge, modes, gaps, reset, config change.
module tb_sobel_stream;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int DW   = 8;
  localparam int NRES = (W - 2) * (H - 2);

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          pi_flag    = 1'b0;
  logic [DW-1:0] pi_data    = '0;
  logic          cfg_mode   = 1'b0;
  logic [DW+2:0] cfg_thresh = '0;
  logic          po_flag;
  logic [DW-1:0] po_data;
  logic          po_eof;

  always #5 clk = ~clk;

  sobel_stream #(
    .IMG_W (W),
    .IMG_H (H),
    .DW    (DW)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .pi_flag    (pi_flag),
    .pi_data    (pi_data),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .po_flag    (po_flag),
    .po_data    (po_data),
    .po_eof     (po_eof)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] out_d [$];
  logic          out_e [$];
  int unsigned   out_c [$];
  int unsigned   trig_c [$];

  always @(negedge clk) begin
    if (po_flag === 1'b1) begin
      out_d.push_back(po_data);
      out_e.push_back(po_eof);
      out_c.push_back(cyc);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_tests++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    out_d.delete();
    out_e.delete();
    out_c.delete();
    trig_c.delete();
  endtask

  // kind 0: flat 100; kind 1: columns 0-3 = 0, columns 4-7 = 200
  function automatic logic [DW-1:0] pix(input int kind, input int x);
    if (kind == 0) return 8'd100;
    return (x >= 4) ? 8'd200 : 8'd0;
  endfunction

  task automatic send_frame(input int kind, input int gap, input int toggle_at);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y * W + x == toggle_at) begin
          cfg_mode   = 1'b1;
          cfg_thresh = '0;
        end
        pi_data = pix(kind, x);
        pi_flag = 1'b1;
        if (x >= 2 && y >= 2) trig_c.push_back(cyc);
        step();
        pi_flag = 1'b0;
        repeat (gap) step();
      end
    end
  endtask

  // Centres 3 and 4 of the step image see |Gx| = 800; every other centre sees 0.
  task automatic check_frame(input string tag, input int off, input logic [DW-1:0] hi,
                             input logic [DW-1:0] lo, input int kind);
    int cx;
    logic [DW-1:0] req;
    if (out_d.size() >= off + NRES && trig_c.size() >= off + NRES) begin
      for (int i = 0; i < NRES; i++) begin
        cx  = 1 + (i % (W - 2));
        req = (kind == 1 && (cx == 3 || cx == 4)) ? hi : lo;
        chk($sformatf("%s_data%0d", tag, i), 32'(out_d[off+i]), 32'(req));
        chk($sformatf("%s_eof%0d", tag, i), 32'(out_e[off+i]), (i == NRES - 1) ? 32'd1 : 32'd0);
        chk($sformatf("%s_lat%0d", tag, i), out_c[off+i] - trig_c[off+i], 32'd3);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_po_flag", 32'(po_flag), 32'd0);
    chk("rst_po_data", 32'(po_data), 32'd0);
    chk("rst_po_eof",  32'(po_eof),  32'd0);
    rst_n = 1'b1;
    step();

    clear_logs();
    cfg_mode = 1'b0;
    send_frame(0, 0, -1);
    repeat (6) step();
    chk("flat_count", out_d.size(), NRES);
    check_frame("flat", 0, 8'd0, 8'd0, 0);

    clear_logs();
    send_frame(1, 0, -1);
    repeat (6) step();
    chk("mag_count", out_d.size(), NRES);
    check_frame("mag", 0, 8'd255, 8'd0, 1);

    clear_logs();
    cfg_mode   = 1'b1;
    cfg_thresh = 11'd400;
    send_frame(1, 0, -1);
    repeat (6) step();
    chk("bin400_count", out_d.size(), NRES);
    check_frame("bin400", 0, 8'd255, 8'd0, 1);

    clear_logs();
    cfg_thresh = 11'd801;
    send_frame(1, 0, -1);
    repeat (6) step();
    chk("bin801_count", out_d.size(), NRES);
    check_frame("bin801", 0, 8'd0, 8'd0, 1);

    clear_logs();
    cfg_mode   = 1'b0;
    cfg_thresh = '0;
    send_frame(1, 434, -1);
    repeat (6) step();
    chk("gap_count", out_d.size(), NRES);
    check_frame("gap", 0, 8'd255, 8'd0, 1);

    clear_logs();
    for (int i = 0; i < 20; i++) begin
      pi_data = pix(1, i % W);
      pi_flag = 1'b1;
      step();
    end
    pi_flag = 1'b0;
    rst_n   = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_po_flag", 32'(po_flag), 32'd0);
    chk("midrst_po_data", 32'(po_data), 32'd0);
    repeat (5) step();
    chk("midrst_quiet", out_d.size(), 32'd0);
    clear_logs();
    send_frame(1, 0, -1);
    repeat (6) step();
    chk("postrst_count", out_d.size(), NRES);
    check_frame("postrst", 0, 8'd255, 8'd0, 1);

    clear_logs();
    cfg_mode   = 1'b0;
    cfg_thresh = 11'd801;
    send_frame(1, 0, 30);
    send_frame(1, 0, -1);
    repeat (6) step();
    chk("tog_count", out_d.size(), 2 * NRES);
    check_frame("tog_cur", 0, 8'd255, 8'd0, 1);
    check_frame("tog_next", NRES, 8'd255, 8'd255, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Parametrised streaming Sobel edge engine. It is the next generation of the fixed-size `sobel_ctrl`, sitting between `uart_rx` (or any pixel source) and `tft_pic` on the `clk_50m` domain. It accepts a raster-order grayscale pixel stream of IMG_W × IMG_H and emits one result per interior pixel, (IMG_W-2)×(IMG_H-2) per frame. Image size and pixel width are set by parameters; output mode (saturated magnitude or thresholded binary) and threshold are selected at run time, frame by frame, with an end-of-frame marker.

## Interface
- IMG_W, default 100: pixels per line, ≥ 3.
- IMG_H, default 100: lines per frame, ≥ 3.
- DW, default 8: pixel width in and out.
- sys_clk  in  1  single clock (`clk_50m` at top level).
- sys_rst_n  in  1  reset, synchronous, active-low.
- pi_flag  in  1  input pixel valid; one pixel per high cycle; may be high every cycle.
- pi_data  in  DW  input pixel, unsigned grayscale.
- cfg_mode  in  1  0 = magnitude, 1 = binary threshold.
- cfg_thresh  in  DW+3  binary-mode threshold, unsigned.
- po_flag  out  1  output pixel valid, single cycle per result.
- po_data  out  DW  result pixel.
- po_eof  out  1  high with the last result of a frame.

## Operation
- col counter runs 0..IMG_W-1 and row counter runs 0..IMG_H-1. Both advance only on pi_flag.
  - col wraps to 0 and increments row.
  - After (IMG_W-1, IMG_H-1) both wrap to 0, ready for the next frame.
- Line buffer holds the previous two lines, addressed by col.
  - A read and write at the same address in the same cycle returns the old data.
  - On each accepted pixel, the stored row y-1 moves to the row y-2 slot and pi_data is written to the row y-1 slot.
- 3×3 window register: on each accepted pixel, shift left one column.
  - Load the new right column from {buf row y-2, buf row y-1, pi_data}.
  - At col=0, the window contents are invalid, and validity is tracked by counters only.
- A result is produced when the accepted pixel has col ≥ 2 and row ≥ 2. It belongs to centre (col-1, row-1).
- Arithmetic, with p[r][c] meaning window row r, column c:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20).
  - Gy = (p20+2p21+p22) - (p00+2p01+p02).
  - Each is signed DW+3 bits.
  - |Gx| and |Gy| are each ≤ 4·(2^DW-1), which fits DW+2 bits unsigned.
  - sum = |Gx|+|Gy|, DW+3 bits unsigned, with no overflow possible.
- Mode 0: po_data = min(sum, 2^DW-1).
- Mode 1: po_data = all-ones if sum ≥ cfg_thresh, else 0.
- cfg_mode and cfg_thresh are captured into shadow registers on the pixel accepted at (0,0).
  - The shadow values apply to every result of that frame.
  - After reset, the shadow values are mode 0 and threshold 0 until the first (0,0) pixel.
- po_eof is high with the result for centre (IMG_W-2, IMG_H-2).

## Timing
- Reset values: po_flag=0, po_data=0, po_eof=0, counters=0, pipeline valid bits=0, shadow cfg=0. Line buffer contents are not reset.
- The pipeline has 3 stages and a fixed latency of 3 cycles.
  - Cycle N: pi_flag accepted.
  - Cycle N+1: window registered.
  - Cycle N+2: |Gx| and |Gy| registered.
  - Cycle N+3: po_flag, po_data and po_eof registered.
- Throughput is 1 pixel/cycle. There is no backpressure, so the downstream block must accept every po_flag.
- Gaps between pi_flag pulses do not alter results. The pipeline advances every cycle.
- Reset mid-frame:
  - All in-flight results are discarded, and po_flag is low in the cycle after the reset edge.
  - The next pixel is treated as (0,0).
- po_flag is never high for pixels with col<2 or row<2. No border output is produced.
- Between frames, the wrap is seamless: pixel (0,0) of frame k+1 may directly follow (IMG_W-1, IMG_H-1) of frame k.

## Structure
- Shared package `sobel_pkg`:
  - Sobel coefficient constants.
  - Mode encodings MODE_MAG=0 and MODE_BIN=1.
  - Width function for the DW+3 gradient width.
- Sub-module `sobel_line_buf`:
  - Parameters IMG_W and DW.
  - One memory of IMG_W × 2·DW bits.
  - Write-enable and address ports.
  - Read-old-data-on-collision behaviour.
  - Infers block RAM or registers.
- Top `sobel_stream` holds counters, window, gradient pipeline, shadow config and the eof tag.

## Test plan
- Flat image: IMG_W=IMG_H=8, DW=8, all pixels 100, mode 0 → exactly 36 po_flag, all po_data=0, one po_eof on the 36th result.
- Vertical step edge in mode 0: columns 0–3 = 0, columns 4–7 = 200 → centres x=3,4 give 255 (|Gx|=800, saturated), all other results 0.
- Same image in mode 1 with cfg_thresh=400 → 255 at x=3,4, else 0. With cfg_thresh=801 → all 0.
- Spacing: the same frame driven back-to-back and again with 434-cycle gaps → identical po_data sequences, each po_flag exactly 3 cycles after its triggering pi_flag.
- Reset after 20 pixels, then a full frame → no po_flag before the new frame's pixel (2,2)+3 cycles, exactly 36 results, one po_eof.
- cfg_mode toggled mid-frame → current frame unchanged, next frame uses the new mode.
